// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// The stage entry stores rd at RD_MAX bits so one typedef serves any AW up to RD_MAX.
package pipe_pkg;

   localparam int RD_MAX = 8;
   localparam int FWD_RF = 0;
   localparam int R0     = 0;

   typedef struct packed {
      logic              valid;
      logic              wen;
      logic              is_load;
      logic [RD_MAX-1:0] rd;
   } stage_t;

endpackage

// File: rtl/pipe_hazard_sb_match.sv
// Per-operand hazard resolution: finds the youngest in-flight producer of rs and
// decides between stalling and forwarding from the stage holding the result.
module sb_match
   import pipe_pkg::*;
#(
   parameter int AW       = 4,
   parameter int NSTG     = 3,
   parameter int LOAD_RDY = 2,
   parameter int FW       = $clog2(NSTG)
) (
   input  stage_t [NSTG-1:0] ents,
   input  logic [AW-1:0]     rs,
   input  logic              used,
   output logic              stall,
   output logic [FW-1:0]     fwd
);

   logic hit;
   logic hit_load;
   logic active;
   int   hit_k;
   int   rdy;

   always_comb begin
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_k    = 0;
      // Scan oldest to youngest so the youngest match overwrites older ones.
      for (int k = NSTG - 1; k >= 0; k--) begin
         if (ents[k].valid && ents[k].wen && (ents[k].rd == RD_MAX'(rs))) begin
            hit      = 1'b1;
            hit_k    = k;
            hit_load = ents[k].is_load;
         end
      end

      active = hit && used && (rs != AW'(R0));
      rdy    = hit_load ? LOAD_RDY : 1;
      stall  = active && ((hit_k + 1) < rdy);

      // A match in the last tracked stage is served by register-file write-through.
      fwd = FW'(FWD_RF);
      if (active && !stall && ((hit_k + 1) <= (NSTG - 1)))
         fwd = FW'(hit_k + 1);
   end

endmodule

// File: rtl/pipe_hazard_sb.sv
// In-order pipeline hazard scoreboard: stall and forward-select generation for ID.
// Optional PIPE_HAZARD_SB_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_sb
   import pipe_pkg::*;
#(
   parameter int  AW       = 4,
   parameter int  NSTG     = 3,
   parameter int  LOAD_RDY = 2,
   localparam int FW       = $clog2(NSTG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_wen,
   input  logic              id_is_load,
   input  logic [AW-1:0]     id_rd,
   input  logic [AW-1:0]     id_rs1,
   input  logic [AW-1:0]     id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              flush,
   output logic              stall,
   output logic [FW-1:0]     ex_fwd_a,
   output logic [FW-1:0]     ex_fwd_b,
   output logic [2**AW-1:0]  sb_pending
`ifdef PIPE_HAZARD_SB_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   stage_t [NSTG-1:0] ents;
   stage_t            id_ent;
   logic              stall_a;
   logic              stall_b;
   logic [FW-1:0]     fwd_a;
   logic [FW-1:0]     fwd_b;
   logic              issue;

   sb_match #(.AW(AW), .NSTG(NSTG), .LOAD_RDY(LOAD_RDY), .FW(FW)) u_match_a (
      .ents  (ents),
      .rs    (id_rs1),
      .used  (id_rs1_used),
      .stall (stall_a),
      .fwd   (fwd_a)
   );

   sb_match #(.AW(AW), .NSTG(NSTG), .LOAD_RDY(LOAD_RDY), .FW(FW)) u_match_b (
      .ents  (ents),
      .rs    (id_rs2),
      .used  (id_rs2_used),
      .stall (stall_b),
      .fwd   (fwd_b)
   );

   assign stall = id_valid && !flush && (stall_a || stall_b);
   assign issue = id_valid && !stall && !flush;

   // Writes to R0 are recorded as non-writing so they never create hazards.
   always_comb begin
      id_ent         = '0;
      id_ent.valid   = 1'b1;
      id_ent.wen     = id_wen && (id_rd != AW'(R0));
      id_ent.is_load = id_is_load;
      id_ent.rd      = RD_MAX'(id_rd);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ents     <= '0;
         ex_fwd_a <= FW'(FWD_RF);
         ex_fwd_b <= FW'(FWD_RF);
      end else begin
         ents[0]  <= issue ? id_ent : '0;
         for (int k = 1; k < NSTG; k++)
            ents[k] <= ents[k-1];
         ex_fwd_a <= issue ? fwd_a : FW'(FWD_RF);
         ex_fwd_b <= issue ? fwd_b : FW'(FWD_RF);
      end
   end

   always_comb begin
      sb_pending = '0;
      for (int k = 0; k < NSTG; k++)
         if (ents[k].valid && ents[k].wen)
            sb_pending[ents[k].rd[AW-1:0]] = 1'b1;
   end

`ifdef PIPE_HAZARD_SB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Self-checking bench for pipe_hazard_sb at default parameters (AW=4, NSTG=3, LOAD_RDY=2).
module tb_pipe_hazard_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_wen, id_is_load;
   logic [3:0]  id_rd, id_rs1, id_rs2;
   logic        id_rs1_used, id_rs2_used, flush;
   logic        stall;
   logic [1:0]  ex_fwd_a, ex_fwd_b;
   logic [15:0] sb_pending;
`ifdef PIPE_HAZARD_SB_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_hazard_sb dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_wen      (id_wen),
      .id_is_load  (id_is_load),
      .id_rd       (id_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .flush       (flush),
      .stall       (stall),
      .ex_fwd_a    (ex_fwd_a),
      .ex_fwd_b    (ex_fwd_b),
      .sb_pending  (sb_pending)
`ifdef PIPE_HAZARD_SB_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   typedef struct {
      logic        v, w, ld;
      logic [3:0]  rd, rs1, rs2;
      logic        u1, u2, fl;
      logic        st;
      logic [1:0]  fa, fb;
      logic [15:0] pend;
   } vec_t;

   typedef struct {
      logic [1:0] fa, fb;
      int         id;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[40];

   function automatic vec_t op(bit v, bit w, bit ld, int rd, int rs1, bit u1, int rs2, bit u2,
                               bit st, int fa, int fb, int pend);
      vec_t t;
      t.v = v; t.w = w; t.ld = ld;
      t.rd = 4'(rd); t.rs1 = 4'(rs1); t.rs2 = 4'(rs2);
      t.u1 = u1; t.u2 = u2; t.fl = 1'b0;
      t.st = st; t.fa = 2'(fa); t.fb = 2'(fb); t.pend = 16'(pend);
      return t;
   endfunction

   function automatic vec_t nop(int pend);
      return op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pend);
   endfunction

   task automatic check(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step%0d got=%0h expected=%0h", nm, id, got, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v; id_wen = t.w; id_is_load = t.ld;
      id_rd = t.rd; id_rs1 = t.rs1; id_rs2 = t.rs2;
      id_rs1_used = t.u1; id_rs2_used = t.u2; flush = t.fl;
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic apply(input vec_t t, input int id);
      exp_t e;
      drive(t);
      #1;
      check("stall", id, 32'(stall), 32'(t.st));
      check("pending", id, 32'(sb_pending), 32'(t.pend));
      e.fa = t.fa; e.fb = t.fb; e.id = id;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check("ex_fwd_a", e.id, 32'(ex_fwd_a), 32'(e.fa));
      check("ex_fwd_b", e.id, 32'(ex_fwd_b), 32'(e.fb));
   endtask

   initial begin
      vec_t t;

      // ADD r3 then immediate reader -> EX forward
      vecs[0]  = op(1, 1, 0, 3, 1, 1, 2, 1, 0, 0, 0, 'h0000);
      vecs[1]  = op(1, 1, 0, 7, 3, 1, 2, 1, 0, 1, 0, 'h0008);
      vecs[2]  = nop('h0088);
      vecs[3]  = nop('h0088);
      vecs[4]  = nop('h0080);
      // load-use on rs2: one stall, then MEM forward
      vecs[5]  = op(1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 'h0000);
      vecs[6]  = op(1, 1, 0, 8, 2, 1, 5, 1, 1, 0, 0, 'h0020);
      vecs[7]  = op(1, 1, 0, 8, 2, 1, 5, 1, 0, 0, 2, 'h0020);
      vecs[8]  = nop('h0120);
      vecs[9]  = nop('h0100);
      vecs[10] = nop('h0100);
      // ADD r4, NOP, reader -> fwd 2
      vecs[11] = op(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 'h0000);
      vecs[12] = nop('h0010);
      vecs[13] = op(1, 1, 0, 9, 4, 1, 0, 0, 0, 2, 0, 'h0010);
      vecs[14] = nop('h0210);
      vecs[15] = nop('h0200);
      vecs[16] = nop('h0200);
      // ADD r4, NOP, NOP, reader -> register file
      vecs[17] = op(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 'h0000);
      vecs[18] = nop('h0010);
      vecs[19] = nop('h0010);
      vecs[20] = op(1, 1, 0, 10, 4, 1, 0, 0, 0, 0, 0, 'h0010);
      vecs[21] = nop('h0400);
      vecs[22] = nop('h0400);
      vecs[23] = nop('h0400);
      // ADD r6, SUB r6, reader -> youngest wins
      vecs[24] = op(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 'h0000);
      vecs[25] = op(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 'h0040);
      vecs[26] = op(1, 1, 0, 11, 6, 1, 0, 0, 0, 1, 0, 'h0040);
      vecs[27] = nop('h0840);
      vecs[28] = nop('h0840);
      vecs[29] = nop('h0800);
      // LW r0 then reader of r0
      vecs[30] = op(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000);
      vecs[31] = op(1, 1, 0, 12, 0, 1, 0, 1, 0, 0, 0, 'h0000);
      vecs[32] = nop('h1000);
      vecs[33] = nop('h1000);
      vecs[34] = nop('h1000);
      // rs2 forward from EX
      vecs[35] = op(1, 1, 0, 13, 0, 0, 0, 0, 0, 0, 0, 'h0000);
      vecs[36] = op(1, 1, 0, 14, 0, 0, 13, 1, 0, 0, 1, 'h2000);
      vecs[37] = nop('h6000);
      vecs[38] = nop('h6000);
      vecs[39] = nop('h4000);

      rst = 1'b0;
      drive(nop(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_stall", 0, 32'(stall), 32'h0);
      check("rst_pending", 0, 32'(sb_pending), 32'h0);
      check("rst_fwd_a", 0, 32'(ex_fwd_a), 32'h0);
      check("rst_fwd_b", 0, 32'(ex_fwd_b), 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 40; i++)
         apply(vecs[i], i);

      // load-use stall cancelled by flush
      apply(op(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 'h0000), 100);
      t = op(1, 1, 0, 8, 5, 1, 0, 0, 1, 0, 0, 'h0020);
      drive(t);
      #1;
      check("ldu_stall", 101, 32'(stall), 32'h1);
      t.fl = 1'b1;
      t.st = 1'b0;
      apply(t, 102);
      apply(nop('h0020), 103);
      apply(nop('h0020), 104);

      // reset with three loads in flight
      apply(op(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 'h0000), 110);
      apply(op(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 'h0002), 111);
      apply(op(1, 1, 1, 3, 1, 1, 0, 0, 0, 2, 0, 'h0006), 112);
      t = op(1, 1, 0, 15, 3, 1, 0, 0, 0, 0, 0, 'h0000);
      drive(t);
      #1;
      check("pre_rst_stall", 113, 32'(stall), 32'h1);
      check("pre_rst_pending", 113, 32'(sb_pending), 32'h000e);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("post_rst_pending", 114, 32'(sb_pending), 32'h0);
      check("post_rst_stall", 114, 32'(stall), 32'h0);
      check("post_rst_fwd_a", 114, 32'(ex_fwd_a), 32'h0);
      apply(t, 115);
      apply(nop('h8000), 116);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_sb.md
PIPE_HAZARD_SB -- requirements
Module: pipe_hazard_sb

Interface
REQ-001 SHALL have parameter AW, default 4, register-address width (2**AW registers).
REQ-002 SHALL have parameter NSTG, default 3, number of tracked post-decode stages (0=EX, 1=MEM, 2=WB), legal 2..8.
REQ-003 SHALL have parameter LOAD_RDY, default 2, first stage index whose load result is forwardable, legal 1..NSTG-1.
REQ-004 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: id_valid  in  1  ID holds a valid instruction; id_wen  in  1  instruction writes a register; id_is_load  in  1  instruction is a load; id_rd  in  AW  destination register.
REQ-007 SHALL have ports: id_rs1, id_rs2  in  AW  source registers; id_rs1_used, id_rs2_used  in  1  source is read.
REQ-008 SHALL have port: flush  in  1  taken branch/jump, kills the ID instruction.
REQ-009 SHALL have ports: stall  out  1  hold PC and IF/ID, insert bubble into EX; ex_fwd_a, ex_fwd_b  out  FW=$clog2(NSTG)  forward select for the instruction now in EX (0 = register file, k = result held in stage k).
REQ-010 SHALL have port: sb_pending  out  2**AW  bit r set while any valid tracked entry writes r.

Function
REQ-011 SHALL keep NSTG entries {valid, wen, rd, is_load}; entry 0 is the instruction in EX.
REQ-012 Each cycle entry k SHALL load entry k-1 (k>=1) unconditionally; entry 0 SHALL load the ID instruction when id_valid & !stall & !flush, otherwise a bubble (valid=0).
REQ-013 An instruction with id_rd==0 SHALL be recorded with wen=0 (R0 never written, never hazards).
REQ-014 For each used source rs!=0, the match SHALL be the youngest (lowest k) valid entry with wen & rd==rs; older matches are ignored.
REQ-015 Producer ready index SHALL be LOAD_RDY for loads, 1 otherwise; a match at k SHALL raise stall when k+1 < ready.
REQ-016 stall SHALL be combinational, 0 when id_valid=0 or flush=1, and the OR over both operands.
REQ-017 A non-stalling match at k SHALL register ex_fwd_x = k+1 if k+1 <= NSTG-1, else 0; no match, unused source or rs==0 SHALL register 0.
REQ-018 When entry 0 receives a bubble, ex_fwd_a and ex_fwd_b SHALL register 0 (latency: one cycle ID->EX).
REQ-019 Stage NSTG-1 writes SHALL be visible to same-cycle ID reads (register file write-through is a system requirement).
REQ-020 sb_pending SHALL be combinational from the entry array.

Reset
REQ-021 With rst=0 at a rising edge, all entries SHALL become invalid and ex_fwd_a, ex_fwd_b SHALL be 0; stall and sb_pending are then 0.
REQ-022 Reset mid-operation SHALL discard all in-flight entries; no stall persists into the first post-reset cycle.

Configuration
REQ-023 With PIPE_HAZARD_SB_PERF_EN defined, the block SHALL add outputs stall_cnt (32) and flush_cnt (32), incremented on each cycle with stall=1 / flush=1, saturating at all-ones, cleared by reset.
REQ-024 Without PIPE_HAZARD_SB_PERF_EN, those ports and counters SHALL not exist.

Structure
REQ-025 Package pipe_pkg SHALL hold the stage-entry struct typedef, the forward-select encoding constants (FWD_RF=0) and the R0 address constant.
REQ-026 Sub-module sb_match SHALL find the youngest match and stall/select for one operand; it SHALL be instantiated twice (rs1, rs2).

Verification (defaults NSTG=3, LOAD_RDY=2)
REQ-027 ADD r3 issued, next cycle reads r3 -> stall=0, following cycle ex_fwd_a=1.
REQ-028 LW r5 issued, next reads r5 on rs2 -> stall=1 for exactly one cycle, then issue, ex_fwd_b=2.
REQ-029 ADD r4, NOP, reader of r4 -> ex_fwd_a=2; with two NOPs -> ex_fwd_a=0, no stall.
REQ-030 ADD r6, SUB r6, reader of r6 -> ex_fwd_a=1 (youngest); LW r0 then reader of r0 -> stall=0, ex_fwd=0, sb_pending[0]=0.
REQ-031 Load-use stall active and flush=1 same cycle -> stall=0, entry 0 bubble, ex_fwd_a=ex_fwd_b=0; rst=0 with three loads in flight -> sb_pending=0 next cycle.
